// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display.
// Segment and digit-select encodings are active-low (common-anode hardware).
package display_pkg;

  // Scan FSM: dead-time blank, then the digit is driven.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // One stored digit: enable flag plus hex value.
  typedef struct packed {
    logic       en;
    logic [3:0] value;
  } digit_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] DIG_OFF = 4'hF;

  // Hex glyphs, active-low, bit0 = a ... bit6 = g. Element 0 is the last entry.
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Active-low one-cold digit select for a scan index.
  function automatic logic [3:0] digit_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_seg7_hex_decoder.sv
// Combinational hex-to-7-segment decoder (active-low segments).
module seg7_hex_decoder
  import display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] segments
);

  // Table lookup of the glyph for the current value.
  always_comb begin
    segments = HEX_GLYPHS[value];
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Round-robin scan scheduler for a 4-digit common-anode 7-segment display.
// Each digit slot is a BLANK dead-time followed by a SHOW dwell. Digit values
// are written into shadow registers and copied to the active set only at the
// frame boundary (end of SHOW for digit 0), so a multi-digit value never tears.
// Optional feature: define DISPLAY_SCAN_LZB_EN for leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 4667,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_digit,
  input  logic [3:0] wr_value,
  input  logic       wr_enable,
  input  logic       commit,
  output logic       frame_tick,
  output logic [6:0] Display,
  output logic [3:0] Digito
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_e       state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              ready_q, ready_d;
  logic              tick_q, tick_d;
  logic [6:0]        display_q, display_d;
  logic [3:0]        digito_q, digito_d;
  digit_t [3:0]      shadow_q, shadow_d;
  digit_t [3:0]      active_q, active_d;

  logic              boundary;
  logic              lead_zero;
  logic [6:0]        glyph;

  // The single decoder looks at the active digit for the current scan index.
  seg7_hex_decoder u_decoder (
    .value    (active_q[idx_q].value),
    .segments (glyph)
  );

  // The frame ends on the last dwell cycle of digit 0.
  assign boundary = (state_q == SHOW) && (idx_q == 2'd0) && (cnt_q == DWELL_LAST);

`ifdef DISPLAY_SCAN_LZB_EN
  // Suppress a digit when it and every digit to its left are zero or disabled.
  always_comb begin
    lead_zero = (idx_q != 2'd0);
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(idx_q) && active_q[k].en && (active_q[k].value != 4'd0)) begin
        lead_zero = 1'b0;
      end
    end
  end
`else
  assign lead_zero = 1'b0;
`endif

  // Shadow writes, commit bookkeeping and the frame-boundary copy.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    if (wr_valid && ready_q) begin
      shadow_d[wr_digit] = '{en: wr_enable, value: wr_value};
    end
    if (boundary) begin
      // A write in this same cycle is already in shadow_d and is included.
      if (pending_q || commit) begin
        active_d = shadow_d;
      end
      pending_d = 1'b0;
      tick_d    = 1'b1;
    end else if (commit) begin
      pending_d = 1'b1;
    end
    ready_d = ~pending_d;
  end

  // Scan FSM: slot timing and the registered digit/segment drive.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CNT_W'(1);
    display_d = display_q;
    digito_d  = digito_q;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          // Disabled digits keep their slot but stay dark, so brightness is constant.
          if (active_q[idx_q].en && !lead_zero) begin
            digito_d  = digit_select(idx_q);
            display_d = glyph;
          end else begin
            digito_d  = DIG_OFF;
            display_d = SEG_OFF;
          end
        end
      end
      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_d   = BLANK;
          idx_d     = idx_q - 2'd1;
          cnt_d     = '0;
          digito_d  = DIG_OFF;
          display_d = SEG_OFF;
        end
      end
      default: begin
        state_d   = BLANK;
        cnt_d     = '0;
        digito_d  = DIG_OFF;
        display_d = SEG_OFF;
      end
    endcase
  end

  // State register; reset blanks the display and discards shadow and commit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= BLANK;
      idx_q     <= 2'd3;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      tick_q    <= 1'b0;
      display_q <= SEG_OFF;
      digito_q  <= DIG_OFF;
      shadow_q  <= '0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      tick_q    <= tick_d;
      display_q <= display_d;
      digito_q  <= digito_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  assign wr_ready   = ready_q;
  assign frame_tick = tick_q;
  assign Display    = display_q;
  assign Digito     = digito_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DWELL_CYCLES=8, BLANK_CYCLES=2).
// Honours DISPLAY_SCAN_LZB_EN in its reference model when defined.
module tb_display_scan_ctrl;

  localparam int DWELL   = 8;
  localparam int BLANK_N = 2;
  localparam int SLOT    = DWELL + BLANK_N;
  localparam int FRAME   = 4 * SLOT;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_digit = 2'd0;
  logic [3:0] wr_value = 4'd0;
  logic       wr_enable = 1'b0;
  logic       commit = 1'b0;
  logic       frame_tick;
  logic [6:0] Display;
  logic [3:0] Digito;

  int checks = 0;
  int passes = 0;

  // Reference model: frame position, shadow/active digits, commit pending.
  int         mp;
  bit         m_pending;
  logic [3:0] sh_val [4];
  bit         sh_en  [4];
  logic [3:0] act_val [4];
  bit         act_en  [4];
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  display_scan_ctrl #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK_N)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_digit   (wr_digit),
    .wr_value   (wr_value),
    .wr_enable  (wr_enable),
    .commit     (commit),
    .frame_tick (frame_tick),
    .Display    (Display),
    .Digito     (Digito)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s at t=%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
  endtask

  // Expected {Digito, Display} for the current frame position.
  function automatic logic [10:0] expOutputs();
    int idx;
    bit dark;
    logic [3:0] sel;
    if ((mp % SLOT) < BLANK_N) return {4'hF, 7'h7F};
    idx  = 3 - (mp / SLOT);
    dark = !act_en[idx];
`ifdef DISPLAY_SCAN_LZB_EN
    if (idx > 0) begin
      bit lz = 1'b1;
      for (int j = idx; j < 4; j++) if (act_en[j] && act_val[j] != 4'd0) lz = 1'b0;
      if (lz) dark = 1'b1;
    end
`endif
    if (dark) return {4'hF, 7'h7F};
    sel = 4'hF;
    sel[idx] = 1'b0;
    return {sel, glyph[act_val[idx]]};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input bit v, input int d, input int val, input bit en, input bit cm);
    logic [10:0] e;
    wr_valid  = v;
    wr_digit  = d[1:0];
    wr_value  = val[3:0];
    wr_enable = en;
    commit    = cm;
    @(posedge clock);
    if (v && !m_pending) begin
      sh_val[d[1:0]] = val[3:0];
      sh_en[d[1:0]]  = en;
    end
    if (mp == FRAME - 1) begin
      if (m_pending || cm) begin
        for (int k = 0; k < 4; k++) begin
          act_val[k] = sh_val[k];
          act_en[k]  = sh_en[k];
        end
      end
      m_pending = 1'b0;
    end else if (cm) begin
      m_pending = 1'b1;
    end
    mp = (mp + 1) % FRAME;
    @(negedge clock);
    e = expOutputs();
    checkOutput("Digito", 32'(Digito), 32'(e[10:7]));
    checkOutput("Display", 32'(Display), 32'(e[6:0]));
    checkOutput("wr_ready", 32'(wr_ready), 32'(!m_pending));
    checkOutput("frame_tick", 32'(frame_tick), 32'(mp == 0));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic waitPos(input int p);
    while (mp != p) idle(1);
  endtask

  initial begin
    bit anchored;
    bit was_pending;
    int guard;
    mp = 0;
    m_pending = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sh_val[k] = 4'd0; sh_en[k] = 1'b0; act_val[k] = 4'd0; act_en[k] = 1'b0;
    end

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_Digito", 32'(Digito), 32'hF);
    checkOutput("rst_Display", 32'(Display), 32'h7F);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_frame_tick", 32'(frame_tick), 32'd0);
    reset_n = 1'b1;

    // With nothing written the display stays dark; find the first frame tick.
    anchored = 1'b0;
    for (int c = 0; c < 3 * FRAME && !anchored; c++) begin
      @(negedge clock);
      if (frame_tick === 1'b1) anchored = 1'b1;
      else begin
        checkOutput("idle_Digito", 32'(Digito), 32'hF);
        checkOutput("idle_Display", 32'(Display), 32'h7F);
      end
    end
    checkOutput("first_tick_seen", 32'(anchored), 32'd1);

    if (anchored) begin
      mp = 0;
      idle(FRAME);

      // Digits 3..0 = 2,3,4,8 then commit.
      applyStimulus(1'b1, 3, 2, 1'b1, 1'b0);
      applyStimulus(1'b1, 2, 3, 1'b1, 1'b0);
      applyStimulus(1'b1, 1, 4, 1'b1, 1'b0);
      applyStimulus(1'b1, 0, 8, 1'b1, 1'b1);
      idle(2 * FRAME);

      // Uncommitted write must not reach the display.
      applyStimulus(1'b1, 1, 5, 1'b1, 1'b0);
      idle(3 * FRAME);

      // Commit mid-frame, then hold a write until the port reopens.
      waitPos(15);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      guard = 0;
      do begin
        was_pending = m_pending;
        applyStimulus(1'b1, 0, 9, 1'b1, 1'b0);
        guard++;
      end while (was_pending && guard < 2 * FRAME);
      checkOutput("held_write_accepted", 32'(was_pending), 32'd0);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      idle(2 * FRAME);

      // Disabled digit 2 keeps its slot dark.
      applyStimulus(1'b1, 2, 7, 1'b0, 1'b1);
      idle(2 * FRAME);

      // Leading-zero pattern 0,0,1,0.
      applyStimulus(1'b1, 3, 0, 1'b1, 1'b0);
      applyStimulus(1'b1, 2, 0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1, 1, 1'b1, 1'b0);
      applyStimulus(1'b1, 0, 0, 1'b1, 1'b1);
      idle(2 * FRAME);

      // Write plus commit exactly on the boundary edge.
      waitPos(FRAME - 1);
      applyStimulus(1'b1, 3, 10, 1'b1, 1'b1);
      idle(FRAME);

      // Randomized traffic.
      for (int i = 0; i < 1200; i++) begin
        applyStimulus(($urandom_range(0, 9) < 3), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0),
                      ($urandom_range(0, 29) == 0));
      end
      idle(FRAME);

      // Reset mid-slot blanks outputs without waiting for a clock edge.
      waitPos(25);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_Digito", 32'(Digito), 32'hF);
      checkOutput("async_Display", 32'(Display), 32'h7F);
      checkOutput("async_wr_ready", 32'(wr_ready), 32'd1);
      checkOutput("async_frame_tick", 32'(frame_tick), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
